multiword_add_sequencer: RTL and testbench

MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

---
 rtl/multiword_add_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_multiword_add_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer
//
// Adds or subtracts two N-bit operands (N = WIDTH*WORDS) by running them
// through one WIDTH-bit sqrt carry-select adder, one slice per clock,
// starting at the least significant slice. The carry between slices is kept
// in a register. Subtraction is A + ~B + 1: the B slices are inverted and
// the carry register starts at 1.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   rst_n      : synchronous active-low reset; overrides flush and all inputs
//   in_valid   : request valid
//   in_ready   : request can be accepted (IDLE only)
//   in_a/in_b  : N-bit operands, captured on accept
//   in_sub     : 1 = A-B, 0 = A+B, captured on accept
//   flush      : synchronous abort back to IDLE; no result is produced
//   busy       : high in RUN or DONE
//   out_valid  : result presented (DONE only)
//   out_ready  : consumer accepts the result
//   out_sum    : N-bit result
//   out_cout   : final carry; for subtract 1 means no borrow
//   out_ovf    : signed two's-complement overflow
//
// Also contains sqrt_carry_select_adder, the WIDTH-bit slice adder.

// sqrt_carry_select_adder
//
// Combinational WIDTH-bit adder split into blocks of growing length
// (1, 2, 3, ...). Each block computes its sum for both carry-in values and the
// real block carry-in selects one, so the select chain is roughly sqrt(WIDTH)
// muxes long instead of WIDTH ripple stages.
//
// Ports
//   a, b : addends
//   cin  : carry in
//   sum  : a + b + cin, low WIDTH bits
//   cout : carry out
module sqrt_carry_select_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic             c_blk;
  logic             c0;
  logic             c1;
  logic [WIDTH-1:0] sum_c;
  int               blk_pos;
  int               blk_len;

  // c0/c1 are the in-block ripple carries assuming block carry-in 0/1;
  // c_blk is the resolved carry entering the current block.
  always_comb begin
    c_blk   = cin;
    c0      = 1'b0;
    c1      = 1'b1;
    sum_c   = '0;
    blk_pos = 0;
    blk_len = 1;
    for (int i = 0; i < WIDTH; i++) begin
      sum_c[i] = c_blk ? (a[i] ^ b[i] ^ c1) : (a[i] ^ b[i] ^ c0);
      c0 = (a[i] & b[i]) | ((a[i] ^ b[i]) & c0);
      c1 = (a[i] & b[i]) | ((a[i] ^ b[i]) & c1);
      if ((blk_pos == blk_len - 1) || (i == WIDTH - 1)) begin
        c_blk   = c_blk ? c1 : c0;
        c0      = 1'b0;
        c1      = 1'b1;
        blk_pos = 0;
        blk_len = blk_len + 1;
      end else begin
        blk_pos = blk_pos + 1;
      end
    end
  end

  assign sum  = sum_c;
  assign cout = c_blk;

endmodule

// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request; in_ready=1
// RUN   | one slice per cycle through the adder, slice index idx_q
// DONE  | result presented on out_*; held until out_ready
module multiword_add_sequencer #(
  parameter int WIDTH = 16,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] in_a,
  input  logic [WIDTH*WORDS-1:0] in_b,
  input  logic                   in_sub,
  input  logic                   flush,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] out_sum,
  output logic                   out_cout,
  output logic                   out_ovf
);

  localparam int N    = WIDTH * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic            sub_q, sub_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [WIDTH-1:0] adder_a;
  logic [WIDTH-1:0] adder_b;
  logic [WIDTH-1:0] adder_sum;
  logic             adder_cout;

  // Slice select for the adder inputs; B is inverted for subtraction.
  always_comb begin
    adder_a = '0;
    adder_b = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (idx_q == IDXW'(w)) begin
        adder_a = a_q[w*WIDTH +: WIDTH];
        adder_b = b_q[w*WIDTH +: WIDTH];
      end
    end
    if (sub_q) begin
      adder_b = ~adder_b;
    end
  end

  sqrt_carry_select_adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a   (adder_a),
    .b   (adder_b),
    .cin (carry_q),
    .sum (adder_sum),
    .cout(adder_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    if (flush) begin
      // Abort: result registers keep their last contents.
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_d     = in_a;
            b_d     = in_b;
            sub_d   = in_sub;
            idx_d   = '0;
            carry_d = in_sub;
            state_d = RUN;
          end
        end
        RUN: begin
          for (int w = 0; w < WORDS; w++) begin
            if (idx_q == IDXW'(w)) begin
              sum_d[w*WIDTH +: WIDTH] = adder_sum;
            end
          end
          carry_d = adder_cout;
          idx_d   = idx_q + IDXW'(1);
          if (idx_q == IDX_LAST) begin
            // adder_b already holds the effective (possibly inverted) B MSB.
            cout_d  = adder_cout;
            ovf_d   = (adder_a[WIDTH-1] == adder_b[WIDTH-1]) &&
                      (adder_sum[WIDTH-1] != adder_a[WIDTH-1]);
            idx_d   = '0;
            state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
module tb_multiword_add_sequencer;

  localparam int WIDTH = 16;
  localparam int WORDS = 4;
  localparam int N     = WIDTH * WORDS;

  typedef struct packed {
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         in_sub;
  logic         flush;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];

  multiword_add_sequencer #(
    .WIDTH(WIDTH),
    .WORDS(WORDS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_sub   (in_sub),
    .flush    (flush),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic on full-width operands.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
    exp_t         e;
    logic [N-1:0] beff;
    logic [N:0]   full;
    beff   = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, beff} + {{N{1'b0}}, sub};
    e.sum  = full[N-1:0];
    e.cout = full[N];
    e.ovf  = (a[N-1] == beff[N-1]) && (full[N-1] != a[N-1]);
    return e;
  endfunction

  // Scoreboard: compare on every output handshake (sampled at negedge).
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", N'(1), N'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("out_sum", out_sum, e.sum);
        chk("out_cout", N'(out_cout), N'(e.cout));
        chk("out_ovf", N'(out_ovf), N'(e.ovf));
      end
    end
  end

  // Drive one request at posedge+1; returns after out_valid has risen.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("ready_timeout", N'(in_ready), N'(1));
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_valid = 1'b1;
    sb_q.push_back(model(a, b, sub));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("busy_after_accept", N'(busy), N'(1));
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", N'(cyc), N'(WORDS));
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
    start_op(a, b, sub);
    @(posedge clk); #1;
    chk("ready_after_done", N'(in_ready), N'(1));
  endtask

  initial begin
    exp_t e;
    int   ones;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", N'(busy), N'(0));
    chk("rst_out_valid", N'(out_valid), N'(0));
    chk("rst_out_sum", out_sum, N'(0));
    chk("rst_out_cout", N'(out_cout), N'(0));
    chk("rst_out_ovf", N'(out_ovf), N'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", N'(in_ready), N'(1));

    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    run_op(64'h5, 64'h7, 1'b1);
    run_op(64'h7, 64'h5, 1'b1);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1);

    // Spot-check the model itself against the directed expectations.
    e = model(64'h5, 64'h7, 1'b1);
    chk("model_sub_borrow", e.sum, 64'hFFFF_FFFF_FFFF_FFFE);
    e = model(64'h8000_0000_0000_0000, 64'h1, 1'b1);
    chk("model_sub_ovf", N'(e.ovf), N'(1));

    for (int k = 0; k < 6; k++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      run_op(ra, rb, 1'($urandom_range(0, 1)));
    end

    // Backpressure: result held, new request ignored while in DONE.
    out_ready = 1'b0;
    start_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
    e = model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_a   = {$urandom, $urandom};
      in_b   = {$urandom, $urandom};
      in_sub = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("bp_out_sum", out_sum, e.sum);
      chk("bp_out_cout", N'(out_cout), N'(e.cout));
      chk("bp_out_valid", N'(out_valid), N'(1));
      chk("bp_in_ready", N'(in_ready), N'(0));
    end
    in_a      = 64'h0000_0001_0000_0002;
    in_b      = 64'h0000_0003_0000_0004;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_after_hs", N'(in_ready), N'(1));
    sb_q.push_back(model(in_a, in_b, in_sub));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_new_accept", N'(busy), N'(1));
    ones = 0;
    while (!out_valid && ones < 100) begin
      @(posedge clk); #1;
      ones++;
    end
    chk("bp_new_latency", N'(ones), N'(WORDS));
    @(posedge clk); #1;

    // Flush on the second RUN cycle.
    in_a     = 64'h1111;
    in_b     = 64'h2222;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready", N'(in_ready), N'(1));
    chk("flush_busy", N'(busy), N'(0));
    ones = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) ones++;
      @(posedge clk); #1;
    end
    chk("flush_no_valid", N'(ones), N'(0));

    // Reset on the second RUN cycle.
    in_a     = 64'hFFFF;
    in_b     = 64'h1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst_busy", N'(busy), N'(0));
    chk("mrst_out_valid", N'(out_valid), N'(0));
    chk("mrst_out_sum", out_sum, N'(0));
    chk("mrst_out_cout", N'(out_cout), N'(0));
    chk("mrst_out_ovf", N'(out_ovf), N'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mrst_in_ready", N'(in_ready), N'(1));
    ones = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) ones++;
      @(posedge clk); #1;
    end
    chk("mrst_no_valid", N'(ones), N'(0));

    run_op(64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_0001, 1'b1);

    chk("scoreboard_empty", N'(sb_q.size()), N'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
